// File: rtl/opl3_pkg.sv
// Shared OPL3 types and constants: the register-write stream and the host front-end entry format.
// The host front end has an optional pending-write FIFO enabled by the OPL3_HOST_FIFO_EN macro.
package opl3_pkg;

    localparam int REG_FILE_DATA_WIDTH     = 8;
    localparam int OPL3_HOST_WR_GAP_CYCLES = 36;
    localparam int OPL3_HOST_FIFO_DEPTH    = 16;

    typedef struct packed {
        logic                           valid;
        logic                           bank_num;
        logic [REG_FILE_DATA_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_reg_wr_t;

    typedef struct packed {
        logic                           bank_num;
        logic [REG_FILE_DATA_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl3_host_entry_t;

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_GAP  = 1'b1
    } opl3_host_state_t;

endpackage

// File: rtl/opl3_host_fifo.sv
// Synchronous show-ahead FIFO for pending host writes; the head entry is visible while not empty.
// Present only when OPL3_HOST_FIFO_EN is defined.
`ifdef OPL3_HOST_FIFO_EN
module opl3_host_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [16:0]
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t wr_entry,
    input  logic   pop,
    output entry_t rd_entry,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

endmodule
`endif

// File: rtl/opl3_host_if.sv
// Host write-port front end: pairs address/data port writes and emits paced opl3_reg_wr pulses.
// OPL3_HOST_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module opl3_host_if
    import opl3_pkg::*;
#(
    parameter int WR_GAP_CYCLES = OPL3_HOST_WR_GAP_CYCLES
`ifdef OPL3_HOST_FIFO_EN
    ,
    parameter int FIFO_DEPTH    = OPL3_HOST_FIFO_DEPTH
`endif
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           host_wr,
    input  logic                           host_rd,
    input  logic [1:0]                     host_addr,
    input  logic [REG_FILE_DATA_WIDTH-1:0] host_din,
    output logic [REG_FILE_DATA_WIDTH-1:0] host_dout,
    output logic                           host_busy,
    output opl3_reg_wr_t                   opl3_reg_wr
);

    localparam logic [7:0] GAP_LOAD = 8'(WR_GAP_CYCLES - 1);

    logic [REG_FILE_DATA_WIDTH-1:0] addr_latch_q, addr_latch_d;
    logic                           bank_latch_q, bank_latch_d;
    logic                           overflow_q, overflow_d;
    logic [REG_FILE_DATA_WIDTH-1:0] host_dout_q, host_dout_d;
    opl3_reg_wr_t                   reg_wr_q, reg_wr_d;
    opl3_host_state_t               state_q, state_d;
    logic [7:0]                     gap_cnt_q, gap_cnt_d;

    logic             addr_wr, data_wr, data_accept, data_drop;
    logic             buf_empty, buf_pop, buf_push, bypass;
    opl3_host_entry_t buf_head, push_entry;

    assign addr_wr     = host_wr && !host_addr[0];
    assign data_wr     = host_wr && host_addr[0];
    assign data_accept = data_wr && !host_busy;
    assign data_drop   = data_wr && host_busy;
    assign push_entry  = '{bank_num: bank_latch_q, address: addr_latch_q, data: host_din};
    assign buf_push    = data_accept && !bypass;

`ifdef OPL3_HOST_FIFO_EN
    logic fifo_full;

    opl3_host_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (opl3_host_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (buf_push),
        .wr_entry (push_entry),
        .pop      (buf_pop),
        .rd_entry (buf_head),
        .full     (fifo_full),
        .empty    (buf_empty)
    );

    assign host_busy = fifo_full;
`else
    logic             hold_valid_q, hold_valid_d;
    opl3_host_entry_t hold_q, hold_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (buf_pop) begin
            hold_valid_d = 1'b0;
        end
        if (buf_push) begin
            hold_valid_d = 1'b1;
            hold_d       = push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign buf_empty = !hold_valid_q;
    assign buf_head  = hold_q;
    assign host_busy = hold_valid_q || (state_q == HOST_GAP);
`endif

    // A write arriving while idle with nothing buffered is issued straight away for N+1 latency.
    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        reg_wr_d       = reg_wr_q;
        reg_wr_d.valid = 1'b0;
        buf_pop        = 1'b0;
        bypass         = 1'b0;
        case (state_q)
            HOST_IDLE: begin
                if (!buf_empty || data_accept) begin
                    buf_pop           = !buf_empty;
                    bypass            = buf_empty;
                    reg_wr_d.valid    = 1'b1;
                    reg_wr_d.bank_num = buf_empty ? push_entry.bank_num : buf_head.bank_num;
                    reg_wr_d.address  = buf_empty ? push_entry.address  : buf_head.address;
                    reg_wr_d.data     = buf_empty ? push_entry.data     : buf_head.data;
                    gap_cnt_d         = GAP_LOAD;
                    if (WR_GAP_CYCLES > 1) begin
                        state_d = HOST_GAP;
                    end
                end
            end
            HOST_GAP: begin
                // The count reaches zero on the cycle the FSM re-enters IDLE, so pulses land
                // exactly WR_GAP_CYCLES apart.
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    state_d = HOST_IDLE;
                end
            end
            default: begin
                state_d = HOST_IDLE;
            end
        endcase
    end

    always_comb begin
        addr_latch_d = addr_latch_q;
        bank_latch_d = bank_latch_q;
        host_dout_d  = host_dout_q;
        overflow_d   = overflow_q;
        if (addr_wr) begin
            addr_latch_d = host_din;
            bank_latch_d = host_addr[1];
        end
        if (host_rd) begin
            host_dout_d = {host_busy, overflow_q, {(REG_FILE_DATA_WIDTH-2){1'b0}}};
            overflow_d  = 1'b0;
        end
        // A drop in the same cycle as a status read must survive the read-clear.
        if (data_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_latch_q <= '0;
            bank_latch_q <= 1'b0;
            overflow_q   <= 1'b0;
            host_dout_q  <= '0;
            reg_wr_q     <= '0;
            state_q      <= HOST_IDLE;
            gap_cnt_q    <= '0;
        end else begin
            addr_latch_q <= addr_latch_d;
            bank_latch_q <= bank_latch_d;
            overflow_q   <= overflow_d;
            host_dout_q  <= host_dout_d;
            reg_wr_q     <= reg_wr_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign host_dout   = host_dout_q;
    assign opl3_reg_wr = reg_wr_q;

endmodule

// File: tb/tb_opl3_host_if.sv
// Directed bench for opl3_host_if: port pairing, bank select, pacing, overflow, status and reset.
// Mode-specific sections follow OPL3_HOST_FIFO_EN.
module tb_opl3_host_if;
    import opl3_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         host_wr;
    logic         host_rd;
    logic [1:0]   host_addr;
    logic [7:0]   host_din;
    logic [7:0]   host_dout;
    logic         host_busy;
    opl3_reg_wr_t reg_wr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    opl3_host_if dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_wr     (host_wr),
        .host_rd     (host_rd),
        .host_addr   (host_addr),
        .host_din    (host_din),
        .host_dout   (host_dout),
        .host_busy   (host_busy),
        .opl3_reg_wr (reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic addr_wr(input logic bank, input logic [7:0] a);
        host_wr   = 1'b1;
        host_addr = {bank, 1'b0};
        host_din  = a;
        tick();
        host_wr   = 1'b0;
    endtask

    task automatic data_wr(input logic a1, input logic [7:0] d);
        host_wr   = 1'b1;
        host_addr = {a1, 1'b1};
        host_din  = d;
        tick();
        host_wr   = 1'b0;
    endtask

    task automatic status_rd();
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input logic bank, input logic [7:0] a,
                             input logic [7:0] d);
        chk({tag, "_valid"}, 32'(reg_wr.valid), 32'd1);
        chk({tag, "_bank"},  32'(reg_wr.bank_num), 32'(bank));
        chk({tag, "_addr"},  32'(reg_wr.address), 32'(a));
        chk({tag, "_data"},  32'(reg_wr.data), 32'(d));
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!reg_wr.valid && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(reg_wr.valid), 32'd1);
    endtask

    initial begin
        int pulses;
        int t0;
        reset_n   = 1'b0;
        host_wr   = 1'b0;
        host_rd   = 1'b0;
        host_addr = 2'b00;
        host_din  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_dout", 32'(host_dout), 32'd0);
        chk("rst_busy", 32'(host_busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic write: pulse appears right after the edge that takes the data strobe.
        addr_wr(1'b0, 8'h20);
        chk("basic_no_emit", 32'(reg_wr.valid), 32'd0);
        data_wr(1'b0, 8'h01);
        chk_pulse("basic", 1'b0, 8'h20, 8'h01);

`ifndef OPL3_HOST_FIFO_EN
        chk("gap_busy0", 32'(host_busy), 32'd1);
        data_wr(1'b0, 8'h02);
        chk("gap_drop_novalid", 32'(reg_wr.valid), 32'd0);
        chk("gap_hold_data", 32'(reg_wr.data), 32'h01);
        repeat (33) tick();
        chk("gap_busy_end", 32'(host_busy), 32'd1);
        tick();
        chk("gap_idle", 32'(host_busy), 32'd0);
        status_rd();
        chk("ovf_rd1", 32'(host_dout), 32'h40);
        status_rd();
        chk("ovf_rd2", 32'(host_dout), 32'h00);
`else
        chk("fifo_busy0", 32'(host_busy), 32'd0);
        repeat (40) tick();
`endif

        // Bank select: bank bit comes from the address-port write only.
        addr_wr(1'b1, 8'hB0);
        data_wr(1'b0, 8'h32);
        chk_pulse("bank", 1'b1, 8'hB0, 8'h32);

`ifndef OPL3_HOST_FIFO_EN
        host_wr   = 1'b1;
        host_rd   = 1'b1;
        host_addr = 2'b01;
        host_din  = 8'h33;
        tick();
        host_wr   = 1'b0;
        host_rd   = 1'b0;
        chk("rd_drop_same", 32'(host_dout), 32'h80);
        status_rd();
        chk("rd_drop_kept", 32'(host_dout), 32'hC0);
        status_rd();
        chk("rd_drop_clr", 32'(host_dout), 32'h80);
`endif
        repeat (40) tick();

        // Address reuse; data-port A1 set high must not alter the bank.
        addr_wr(1'b0, 8'hA0);
        data_wr(1'b1, 8'h11);
        chk_pulse("reuse1", 1'b0, 8'hA0, 8'h11);
        repeat (40) tick();
        data_wr(1'b0, 8'h22);
        chk_pulse("reuse2", 1'b0, 8'hA0, 8'h22);
        repeat (40) tick();

`ifdef OPL3_HOST_FIFO_EN
        // Pacing: four back-to-back writes emerge 36 cycles apart.
        data_wr(1'b0, 8'h10);
        t0 = cyc;
        chk_pulse("pace0", 1'b0, 8'hA0, 8'h10);
        data_wr(1'b0, 8'h11);
        data_wr(1'b0, 8'h12);
        data_wr(1'b0, 8'h13);
        for (int k = 1; k < 4; k++) begin
            wait_valid("pace", 100);
            chk("pace_spacing", 32'(cyc - t0), 32'(36 * k));
            chk("pace_data", 32'(reg_wr.data), 32'(8'h10 + k));
            chk("pace_busy", 32'(host_busy), 32'd0);
            tick();
        end
        repeat (40) tick();

        // Overflow: burst of 18 while in the gap fills 16 and drops the last two.
        data_wr(1'b0, 8'h5A);
        chk_pulse("ovf_lead", 1'b0, 8'hA0, 8'h5A);
        for (int k = 0; k < 18; k++) begin
            data_wr(1'b0, 8'(8'h60 + k));
        end
        status_rd();
        chk("fifo_ovf_rd1", 32'(host_dout), 32'hC0);
        status_rd();
        chk("fifo_ovf_rd2", 32'(host_dout), 32'h80);
        wait_valid("fifo_drain", 60);
        chk("fifo_drain_data", 32'(reg_wr.data), 32'h60);
`else
        data_wr(1'b0, 8'h77);
        chk_pulse("pre_rst", 1'b0, 8'hA0, 8'h77);
`endif

        // Reset mid-operation: valid drops without waiting for a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(reg_wr.valid), 32'd0);
        chk("mid_rst_reg", 32'(reg_wr), 32'd0);
        chk("mid_rst_busy", 32'(host_busy), 32'd0);
        chk("mid_rst_dout", 32'(host_dout), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (reg_wr.valid) pulses++;
        end
        chk("post_rst_quiet", 32'(pulses), 32'd0);
        data_wr(1'b0, 8'h05);
        chk_pulse("post_rst", 1'b0, 8'h00, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
